// File: rtl/zbus_pkg.sv
// Shared types for the ZX-bus I/O cycle sequencer: the bus-owner encoding,
// the FSM state encoding, and the owner priority resolver.
package zbus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INT  = 2'd1,
    OWN_EXT1 = 2'd2,
    OWN_EXT2 = 2'd3
  } owner_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_INTA    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Internal decoder beats external claims; EXT1 beats EXT2 when both claim.
  function automatic owner_t pick_owner(input logic hit, input logic ge1, input logic ge2);
    owner_t o;
    if (hit)      o = OWN_INT;
    else if (ge1) o = OWN_EXT1;
    else if (ge2) o = OWN_EXT2;
    else          o = OWN_NONE;
    return o;
  endfunction

endpackage

// File: rtl/zbus_sync.sv
// N-stage synchronizer for one asynchronous input. The reset level is a
// parameter so active-low strobes can reset to their idle (high) level.
module zbus_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] pipe;

  // Shift the raw input through the flop chain; reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) pipe <= {STAGES{RST_VAL}};
    else     pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/zbus_cycle_ctrl.sv
// Z80 I/O and interrupt-acknowledge cycle sequencer. Synchronizes the raw
// strobes and IORQGE lines, decides the owner of each I/O cycle and emits
// single-cycle begin/end pulses plus the 0xFF bus-drive enable.
//
// Strobe semantics: iord_begin/iowr_begin/inta_begin/iord_end/iowr_end are
// one-cycle pulses with no back-pressure; consumers must accept them in the
// cycle they appear. owner is valid from the begin pulse through the end pulse.
module zbus_cycle_ctrl
  import zbus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GE_SETTLE   = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic       iorqge1,
  input  logic       iorqge2,
  input  logic       porthit,
  output logic       iord_begin,
  output logic       iowr_begin,
  output logic       iord_end,
  output logic       iowr_end,
  output logic       inta_begin,
  output logic [1:0] owner,
  output logic       drive_ff,
  output logic       busy,
  output logic       err_timeout,
  output logic [2:0] fsm_state
);

  localparam int         SW     = (GE_SETTLE > 1) ? $clog2(GE_SETTLE) : 1;
  localparam int         WW     = $clog2(SYNC_STAGES + 1);
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  // Synchronized raw pins (still at pin polarity for the strobes).
  logic q_iorq, q_rd, q_wr, q_m1, q_ge1, q_ge2;
  // Active-high internal views.
  logic s_iorq, s_rd, s_wr, s_m1, s_ge1, s_ge2;

  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iorq (.clk(fclk), .rst(rst), .d(iorq_n),  .q(q_iorq));
  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd   (.clk(fclk), .rst(rst), .d(rd_n),    .q(q_rd));
  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr   (.clk(fclk), .rst(rst), .d(wr_n),    .q(q_wr));
  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_m1   (.clk(fclk), .rst(rst), .d(m1_n),    .q(q_m1));
  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ge1  (.clk(fclk), .rst(rst), .d(iorqge1), .q(q_ge1));
  zbus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ge2  (.clk(fclk), .rst(rst), .d(iorqge2), .q(q_ge2));

  assign s_iorq = ~q_iorq;
  assign s_rd   = ~q_rd;
  assign s_wr   = ~q_wr;
  assign s_m1   = ~q_m1;
  assign s_ge1  = q_ge1;
  assign s_ge2  = q_ge2;

  // State and datapath registers.
  state_t        state, state_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic          dir_rd, dir_n;
  owner_t        owner_q, owner_n;
  logic [7:0]    tcnt, tcnt_n;
  logic          err_q, err_n;
  logic          iord_begin_n, iowr_begin_n, iord_end_n, iowr_end_n, inta_begin_n;
  logic          drive_n;

  // Arming logic: after reset the synchronizers hold the idle level until
  // they have filled, so a cycle already in progress would look like a fresh
  // one. New cycles are accepted only after the filled pipeline has shown
  // iorq deasserted while idle.
  logic [WW-1:0] warm_cnt;
  logic          warm_done;
  logic          armed;

  assign warm_done = (warm_cnt == WW'(SYNC_STAGES));

  // Track synchronizer fill and arm once a clean idle bus is observed.
  always_ff @(posedge fclk) begin
    if (rst) begin
      warm_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
      if (warm_done && state == ST_IDLE && !s_iorq) armed <= 1'b1;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      dir_rd      <= 1'b0;
      owner_q     <= OWN_NONE;
      tcnt        <= '0;
      err_q       <= 1'b0;
      iord_begin  <= 1'b0;
      iowr_begin  <= 1'b0;
      iord_end    <= 1'b0;
      iowr_end    <= 1'b0;
      inta_begin  <= 1'b0;
      drive_ff    <= 1'b0;
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_n;
      dir_rd      <= dir_n;
      owner_q     <= owner_n;
      tcnt        <= tcnt_n;
      err_q       <= err_n;
      iord_begin  <= iord_begin_n;
      iowr_begin  <= iowr_begin_n;
      iord_end    <= iord_end_n;
      iowr_end    <= iowr_end_n;
      inta_begin  <= inta_begin_n;
      drive_ff    <= drive_n;
    end
  end

  // Next-state, cycle ownership and pulse generation.
  always_comb begin
    state_n      = state;
    settle_n     = settle_cnt;
    dir_n        = dir_rd;
    owner_n      = owner_q;
    tcnt_n       = tcnt;
    err_n        = err_q;
    iord_begin_n = 1'b0;
    iowr_begin_n = 1'b0;
    iord_end_n   = 1'b0;
    iowr_end_n   = 1'b0;
    inta_begin_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (armed && s_iorq && s_m1) begin
          state_n      = ST_INTA;
          inta_begin_n = 1'b1;
        end else if (armed && s_iorq && !s_m1 && (s_rd || s_wr)) begin
          state_n  = ST_SETTLE;
          settle_n = '0;
        end
      end

      ST_SETTLE: begin
        if (!s_iorq) begin
          // Aborted before ownership was decided: no strobes at all.
          state_n = ST_IDLE;
        end else if (settle_cnt == SW'(GE_SETTLE - 1)) begin
          state_n      = ST_ACTIVE;
          owner_n      = pick_owner(porthit, s_ge1, s_ge2);
          dir_n        = s_rd;
          tcnt_n       = '0;
          iord_begin_n = s_rd;
          iowr_begin_n = !s_rd;
        end else begin
          settle_n = settle_cnt + 1'b1;
        end
      end

      ST_ACTIVE: begin
        // Only the direction latched at begin decides when the cycle ends.
        if (!s_iorq || (dir_rd ? !s_rd : !s_wr)) begin
          state_n    = ST_RECOVER;
          iord_end_n = dir_rd;
          iowr_end_n = !dir_rd;
        end else begin
          if (tcnt != TO_MAX) tcnt_n = tcnt + 8'd1;
          if (tcnt_n == TO_MAX) err_n = 1'b1;
        end
      end

      ST_INTA: begin
        if (!s_iorq || !s_m1) state_n = ST_RECOVER;
      end

      ST_RECOVER: begin
        owner_n = OWN_NONE;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end
    endcase

    // Float-bus fill: unclaimed reads and the whole INTA cycle get 0xFF.
    drive_n = ((state_n == ST_ACTIVE) && (owner_n == OWN_NONE) && dir_n) ||
              (state_n == ST_INTA);
  end

  assign owner       = owner_q;
  assign busy        = (state != ST_IDLE);
  assign err_timeout = err_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_zbus_cycle_ctrl.sv
// Bench for zbus_cycle_ctrl: directed Z80 cycles, expected pulse events
// queued by the driver and checked by a decoupled monitor.
module tb_zbus_cycle_ctrl;

  logic       fclk;
  logic       rst;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic       iorqge1, iorqge2, porthit;
  logic       iord_begin, iowr_begin, iord_end, iowr_end, inta_begin;
  logic [1:0] owner;
  logic       drive_ff, busy, err_timeout;
  logic [2:0] fsm_state;

  zbus_cycle_ctrl #(.SYNC_STAGES(2), .GE_SETTLE(2), .TIMEOUT(255)) dut (
    .fclk(fclk), .rst(rst),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .iorqge1(iorqge1), .iorqge2(iorqge2), .porthit(porthit),
    .iord_begin(iord_begin), .iowr_begin(iowr_begin),
    .iord_end(iord_end), .iowr_end(iowr_end), .inta_begin(inta_begin),
    .owner(owner), .drive_ff(drive_ff), .busy(busy),
    .err_timeout(err_timeout), .fsm_state(fsm_state)
  );

  // Event kinds
  localparam logic [3:0] K_RDB = 4'd1, K_WRB = 4'd2, K_RDE = 4'd3, K_WRE = 4'd4, K_INTA = 4'd5;

  // Expected event word: {cycle[15:0], kind[3:0], owner[1:0], drive_ff, 1'b0}
  logic [23:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // ---------------- clock/reset ----------------
  initial fclk = 1'b0;
  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  function automatic logic [23:0] ev(input int c, input logic [3:0] k, input logic [1:0] o, input logic d);
    return {16'(c), k, o, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge fclk);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [4:0]  pulses;
    logic [3:0]  k;
    logic [23:0] act, exp;
    forever begin
      @(negedge fclk);
      pulses = {iord_begin, iowr_begin, iord_end, iowr_end, inta_begin};
      if (pulses != 5'b0) begin
        case (pulses)
          5'b10000: k = K_RDB;
          5'b01000: k = K_WRB;
          5'b00100: k = K_RDE;
          5'b00010: k = K_WRE;
          5'b00001: k = K_INTA;
          default:  k = 4'hF;
        endcase
        act = {16'(cyc), k, owner, drive_ff, 1'b0};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse: got %h expected none (cycle %0d)", act, cyc);
        end else begin
          exp = exp_q.pop_front();
          check("pulse_event", 32'(act), 32'(exp));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    iorqge1 = 1'b0; iorqge2 = 1'b0; porthit = 1'b0;
  endtask

  // Start an I/O cycle; begin pulse expected SYNC+1+SETTLE = 5 edges later.
  task automatic io_start(input logic is_rd, input logic hit, input logic g1, input logic g2,
                          input logic [1:0] exp_own, input logic exp_dff);
    porthit = hit; iorqge1 = g1; iorqge2 = g2;
    iorq_n = 1'b0;
    if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
    exp_q.push_back(ev(cyc + 5, is_rd ? K_RDB : K_WRB, exp_own, exp_dff));
  endtask

  // Release strobes; end pulse expected SYNC+1 = 3 edges later, drive_ff low.
  task automatic io_stop(input logic is_rd, input logic [1:0] exp_own);
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    exp_q.push_back(ev(cyc + 3, is_rd ? K_RDE : K_WRE, exp_own, 1'b0));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({iord_begin, iowr_begin, iord_end, iowr_end, inta_begin, owner, drive_ff, busy, err_timeout});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    fork monitor(); join_none
    bus_idle();
    rst = 1'b1;
    step(3);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    step(6);

    // Read claimed by the internal decoder
    io_start(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    step(10);
    check("int_rd_owner", 32'(owner), 32'd1);
    check("int_rd_dff", 32'(drive_ff), 32'd0);
    io_stop(1'b1, 2'd1);
    step(6);
    check("int_rd_idle_busy", 32'(busy), 32'd0);
    check("int_rd_idle_owner", 32'(owner), 32'd0);
    bus_idle();

    // Unclaimed read: 0xFF fill from begin through end
    io_start(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(10);
    check("none_rd_dff_mid", 32'(drive_ff), 32'd1);
    io_stop(1'b1, 2'd0);
    step(6);
    check("none_rd_dff_after", 32'(drive_ff), 32'd0);
    bus_idle();

    // Read claimed by EXT2
    io_start(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    step(10);
    io_stop(1'b1, 2'd3);
    step(6);
    bus_idle();

    // Write with both GE lines: EXT1 wins
    io_start(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    step(10);
    check("ext1_wr_dff", 32'(drive_ff), 32'd0);
    io_stop(1'b0, 2'd2);
    step(6);
    bus_idle();

    // INTA: pulse after 3 edges, drive_ff until m1_n rise + 3
    m1_n = 1'b0; iorq_n = 1'b0;
    exp_q.push_back(ev(cyc + 3, K_INTA, 2'd0, 1'b1));
    step(10);
    check("inta_dff_mid", 32'(drive_ff), 32'd1);
    m1_n = 1'b1; iorq_n = 1'b1;
    step(2);
    check("inta_dff_hold", 32'(drive_ff), 32'd1);
    step(1);
    check("inta_dff_drop", 32'(drive_ff), 32'd0);
    step(4);

    // Short iorq pulse (shorter than the settle window): no strobes
    iorq_n = 1'b0; rd_n = 1'b0;
    step(2);
    iorq_n = 1'b1; rd_n = 1'b1;
    step(8);
    check("short_busy", 32'(busy), 32'd0);

    // Stuck read: timeout flag
    io_start(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    step(300);
    check("timeout_set", 32'(err_timeout), 32'd1);
    check("timeout_active", 32'(busy), 32'd1);

    // Reset mid-cycle: outputs clear, stale cycle ignored
    rst = 1'b1;
    step(1);
    check("midrst_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    step(20);
    check("stale_ignored_busy", 32'(busy), 32'd0);
    bus_idle();
    step(5);
    io_start(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    step(8);
    check("post_rst_err_clear", 32'(err_timeout), 32'd0);
    io_stop(1'b0, 2'd2);
    step(6);
    bus_idle();

    // Drain expected queue, bounded
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge fclk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
